intc_irq_sequencer: RTL and testbench

- Sequences the interrupt controller: captures per-source completion events, applies a software mask, picks one source, drives IRQ/irq_id, and holds the request until IACK.
- After IACK, it blocks further requests until software writes end-of-interrupt (EOI). No nesting.
- Exposes memory-mapped MASK/PEND/STATUS/EOI registers at offsets 0x10–0x1C of the interrupt-controller region. The ISR address table keeps offsets 0x00–0x0C.
- irq_id selects the ISR address from the table.

---
 rtl/intc_irq_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_intc_irq_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_irq_sequencer.sv
// intc_irq_sequencer
// Interrupt sequencer for the interrupt controller. It captures rising edges of
// per-source completion levels, applies a software mask, picks one source, and
// drives IRQ/irq_id until the CPU acknowledges. It then waits for an EOI write
// before raising another request. The MASK/PEND/STATUS/EOI registers sit at
// offsets 0x10-0x1C; offsets 0x00-0x0C belong to the ISR address table and
// read 0 here, so read_data can be ORed with the table read.
// Optional build macro: INTC_ROUND_ROBIN_EN selects round-robin arbitration.
// When it is undefined, arbitration is fixed priority with source 0 highest.

module intc_irq_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'h00020000,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  done,
    input  logic        IACK,
    input  logic [31:0] input_addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        IRQ,
    output logic [1:0]  irq_id,
    output logic        error
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [4:0] OFF_MASK   = 5'h10;
    localparam logic [4:0] OFF_PEND   = 5'h14;
    localparam logic [4:0] OFF_STATUS = 5'h18;
    localparam logic [4:0] OFF_EOI    = 5'h1C;

    logic [1:0]  r_state;
    logic        r_irq;
    logic [1:0]  r_irq_id;
    logic [3:0]  r_pend;
    logic [3:0]  r_mask;
    logic [3:0]  r_done_q;
    logic        r_overrun;
    logic        r_timeout;
    logic [15:0] r_ack_cnt;

    logic        w_hit;
    logic [4:0]  w_off;
    logic        w_wr_mask;
    logic        w_wr_pend;
    logic        w_wr_status;
    logic        w_wr_eoi;
    logic [3:0]  w_rise;
    logic        w_ack;
    logic [3:0]  w_ack_clr;
    logic [3:0]  w_w1c_clr;
    logic [3:0]  w_pend_nxt;
    logic [3:0]  w_req;
    logic        w_overrun_evt;
    logic        w_timeout_evt;
    logic        w_busy;
    logic [1:0]  w_start;
    logic [1:0]  w_pick;
    logic        w_unused_wdata;

    // Upper write-data bits carry no meaning for any register in this block.
    assign w_unused_wdata = &{1'b0, write_data[31:4]};

    // Picks the first requesting source, searching upward from 'start' and
    // wrapping 3 -> 0.
    function automatic logic [1:0] f_pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        logic [1:0] pick;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_hit       = (input_addr[31:5] == BASE_ADDR[31:5]);
    assign w_off       = input_addr[4:0];
    assign w_wr_mask   = write_enable && w_hit && (w_off == OFF_MASK);
    assign w_wr_pend   = write_enable && w_hit && (w_off == OFF_PEND);
    assign w_wr_status = write_enable && w_hit && (w_off == OFF_STATUS);
    assign w_wr_eoi    = write_enable && w_hit && (w_off == OFF_EOI);

    assign w_rise     = done & ~r_done_q;
    assign w_ack      = (r_state == ST_ASSERT) && IACK;
    assign w_ack_clr  = w_ack ? (4'b0001 << r_irq_id) : 4'b0000;
    assign w_w1c_clr  = w_wr_pend ? write_data[3:0] : 4'b0000;
    // A new rise beats any clear of the same bit in the same cycle.
    assign w_pend_nxt = (r_pend & ~(w_ack_clr | w_w1c_clr)) | w_rise;
    assign w_req      = r_pend & r_mask;

    assign w_overrun_evt = |(w_rise & r_pend);
    assign w_timeout_evt = (r_state == ST_ASSERT) && (r_ack_cnt == ACK_TIMEOUT - 16'd1);
    assign w_busy        = (r_state != ST_IDLE);

`ifdef INTC_ROUND_ROBIN_EN
    logic [1:0] r_rr_ptr;

    // Round-robin pointer remembers the last acknowledged source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= 2'd3;
        end else if (w_ack) begin
            r_rr_ptr <= r_irq_id;
        end
    end

    assign w_start = r_rr_ptr + 2'd1;
`else
    assign w_start = 2'd0;
`endif

    assign w_pick = f_pick(w_req, w_start);

    // Edge-capture register for the completion levels.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (!rst) begin
            r_done_q <= 4'b0000;
        end else begin
            r_done_q <= done;
        end
    end

    // Pending bits: set on rising edges, cleared by IACK or W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= 4'b0000;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Software mask register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= 4'b0000;
        end else if (w_wr_mask) begin
            r_mask <= write_data[3:0];
        end
    end

    // Sticky error flags; a STATUS write clears them unless a new event lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= w_overrun_evt || (r_overrun && !w_wr_status);
            r_timeout <= w_timeout_evt || (r_timeout && !w_wr_status);
        end
    end

    // Request/acknowledge/EOI sequencing with the acknowledge watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
            r_irq_id  <= 2'd0;
            r_ack_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack_cnt <= 16'd0;
                    if (|w_req) begin
                        r_irq_id <= w_pick;
                        r_irq    <= 1'b1;
                        r_state  <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (IACK) begin
                        r_irq     <= 1'b0;
                        r_ack_cnt <= 16'd0;
                        r_state   <= ST_SERVICE;
                    end else if (r_ack_cnt != ACK_TIMEOUT - 16'd1) begin
                        r_ack_cnt <= r_ack_cnt + 16'd1;
                    end
                end
                ST_SERVICE: begin
                    if (w_wr_eoi) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_irq     <= 1'b0;
                    r_ack_cnt <= 16'd0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Register read mux; anything outside this block's registers reads 0.
    always_comb begin
        // NOTE: default first so every path assigns read_data and no latch forms.
        read_data = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_MASK:   read_data = {28'd0, r_mask};
                OFF_PEND:   read_data = {28'd0, r_pend};
                OFF_STATUS: read_data = {27'd0, r_timeout, r_overrun, w_busy, r_irq_id};
                default:    read_data = 32'd0;
            endcase
        end
    end

    assign IRQ    = r_irq;
    assign irq_id = r_irq_id;
    assign error  = r_overrun | r_timeout;

endmodule

// File: tb/tb_intc_irq_sequencer.sv
// Testbench for intc_irq_sequencer. Directed scenarios followed by random
// stimulus; a behavioural model predicts outputs each cycle, expectations are
// queued, and a monitor on the falling edge pops and compares them.

module tb_intc_irq_sequencer;

    localparam logic [31:0] BASE = 32'h00020000;
    localparam int          AT   = 1024;

    localparam logic [31:0] A_MASK   = BASE | 32'h10;
    localparam logic [31:0] A_PEND   = BASE | 32'h14;
    localparam logic [31:0] A_STATUS = BASE | 32'h18;
    localparam logic [31:0] A_EOI    = BASE | 32'h1C;

    logic        clk;
    logic        rst;
    logic [3:0]  done;
    logic        iack;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] read_data;
    logic        irq;
    logic [1:0]  irq_id;
    logic        error;

    intc_irq_sequencer #(
        .BASE_ADDR   (BASE),
        .ACK_TIMEOUT (16'(AT))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .done         (done),
        .IACK         (iack),
        .input_addr   (addr),
        .write_enable (we),
        .write_data   (wd),
        .read_data    (read_data),
        .IRQ          (irq),
        .irq_id       (irq_id),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef enum {M_IDLE, M_WAIT_ACK, M_IN_ISR} mode_t;

    typedef struct {
        logic        irq;
        logic [1:0]  id;
        logic        err;
        logic [31:0] rd;
        string       tag;
    } exp_t;

    exp_t  sb_q[$];
    int    n_cmp;
    int    n_bad;

    mode_t      m_mode;
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic [3:0] m_prev;
    logic [1:0] m_id;
    logic       m_ovr;
    logic       m_tmo;
    int         m_last;
    int         m_edge;
    int         m_entry;
    logic [3:0] cur_done;

    function automatic logic [1:0] pick_src(input logic [3:0] req, input int last);
        int start;
`ifdef INTC_ROUND_ROBIN_EN
        start = (last + 1) % 4;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (req[(start + k) % 4]) return 2'((start + k) % 4);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pend  = 4'd0;
        m_mask  = 4'd0;
        m_prev  = 4'd0;
        m_id    = 2'd0;
        m_ovr   = 1'b0;
        m_tmo   = 1'b0;
        m_last  = 3;
        m_entry = 0;
    endtask

    // Applies one rising edge using the inputs present before that edge.
    task automatic model_edge();
        logic [3:0] rise, clr, old_pend, old_mask;
        logic       hit, ovr_evt, tmo_evt;
        logic [4:0] off;
        m_edge++;
        if (rst) begin
            hit      = (addr[31:5] == BASE[31:5]);
            off      = addr[4:0];
            old_pend = m_pend;
            old_mask = m_mask;
            rise     = done & ~m_prev;
            clr      = 4'd0;
            if (m_mode == M_WAIT_ACK && iack) clr[m_id] = 1'b1;
            if (we && hit && off == 5'h14) clr = clr | wd[3:0];
            ovr_evt  = |(rise & old_pend);
            tmo_evt  = (m_mode == M_WAIT_ACK) && ((m_edge - m_entry) >= AT);
            m_pend   = (old_pend & ~clr) | rise;
            if (we && hit && off == 5'h18) begin
                m_ovr = 1'b0;
                m_tmo = 1'b0;
            end
            if (ovr_evt) m_ovr = 1'b1;
            if (tmo_evt) m_tmo = 1'b1;
            if (we && hit && off == 5'h10) m_mask = wd[3:0];
            case (m_mode)
                M_IDLE: begin
                    if ((old_pend & old_mask) != 4'd0) begin
                        m_id    = pick_src(old_pend & old_mask, m_last);
                        m_mode  = M_WAIT_ACK;
                        m_entry = m_edge;
                    end
                end
                M_WAIT_ACK: begin
                    if (iack) begin
                        m_last = int'(m_id);
                        m_mode = M_IN_ISR;
                    end
                end
                default: begin
                    if (we && hit && off == 5'h1C) m_mode = M_IDLE;
                end
            endcase
            m_prev = done;
        end
    endtask

    function automatic logic [31:0] exp_rd();
        if (addr[31:5] != BASE[31:5]) return 32'd0;
        case (addr[4:0])
            5'h10:   return {28'd0, m_mask};
            5'h14:   return {28'd0, m_pend};
            5'h18:   return {27'd0, m_tmo, m_ovr, (m_mode != M_IDLE), m_id};
            default: return 32'd0;
        endcase
    endfunction

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".irq"},    32'(irq),    32'(e.irq));
                check({e.tag, ".irq_id"}, 32'(irq_id), 32'(e.id));
                check({e.tag, ".error"},  32'(error),  32'(e.err));
                check({e.tag, ".rdata"},  read_data,   e.rd);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------- stimulus
    task automatic step(input string tag, input logic r_v, input logic [3:0] d_v,
                        input logic ack_v, input logic we_v, input logic [31:0] addr_v,
                        input logic [31:0] data_v);
        @(posedge clk);
        model_edge();
        #1;
        rst      = r_v;
        done     = d_v;
        cur_done = d_v;
        iack     = ack_v;
        we       = we_v;
        addr     = addr_v;
        wd       = data_v;
        if (!r_v) model_reset();
        sb_q.push_back('{(m_mode == M_WAIT_ACK), m_id, (m_ovr | m_tmo), exp_rd(), tag});
    endtask

    task automatic rd(input string tag, input logic [3:0] d_v, input logic [31:0] a_v);
        step(tag, 1'b1, d_v, 1'b0, 1'b0, a_v, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [3:0] d_v, input logic [31:0] a_v,
                      input logic [31:0] data_v);
        step(tag, 1'b1, d_v, 1'b0, 1'b1, a_v, data_v);
    endtask

    task automatic ack(input string tag, input logic [3:0] d_v);
        step(tag, 1'b1, d_v, 1'b1, 1'b0, A_STATUS, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, 4'd0, 1'b0, 1'b0, A_STATUS, 32'd0);
    endtask

    initial begin
        logic [1:0] exp_second;
        n_cmp    = 0;
        n_bad    = 0;
        m_edge   = 0;
        rst      = 1'b0;
        done     = 4'd0;
        cur_done = 4'd0;
        iack     = 1'b0;
        we       = 1'b0;
        addr     = A_STATUS;
        wd       = 32'd0;
        model_reset();

        // Basic request / acknowledge / EOI on source 2.
        do_reset("reset");
        do_reset("reset");
        #1;
        check("reset_status", read_data, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        wr("s1_mask", 4'b0000, A_MASK, 32'hF);
        rd("s1_rise", 4'b0100, A_STATUS);
        rd("s1_pend", 4'b0100, A_PEND);
        #1;
        check("s1_pend_val", read_data, 32'h4);
        check("s1_no_irq_yet", 32'(irq), 32'h0);
        rd("s1_irq", 4'b0100, A_STATUS);
        #1;
        check("s1_irq_up", 32'(irq), 32'h1);
        check("s1_irq_id", 32'(irq_id), 32'h2);
        check("s1_status", read_data, 32'h6);
        ack("s1_ack", 4'b0000);
        rd("s1_srv", 4'b0000, A_PEND);
        #1;
        check("s1_irq_dropped", 32'(irq), 32'h0);
        check("s1_pend_clr", read_data, 32'h0);
        wr("s1_eoi", 4'b0000, A_EOI, 32'hDEAD);
        rd("s1_idle", 4'b0000, A_STATUS);
        #1;
        check("s1_not_busy", read_data, 32'h2);

        // Sources 1 and 3 together: serve 1, then 3 after EOI.
        do_reset("s2_reset");
        wr("s2_mask", 4'b0000, A_MASK, 32'hF);
        rd("s2_rise", 4'b1010, A_STATUS);
        rd("s2_pend", 4'b1010, A_STATUS);
        rd("s2_irq", 4'b1010, A_STATUS);
        #1;
        check("s2_first_id", 32'(irq_id), 32'h1);
        ack("s2_ack1", 4'b1010);
        rd("s2_srv1", 4'b1010, A_PEND);
        #1;
        check("s2_pend_left", read_data, 32'h8);
        wr("s2_eoi1", 4'b1010, A_EOI, 32'h0);
        rd("s2_idle", 4'b1010, A_STATUS);
        rd("s2_irq2", 4'b1010, A_STATUS);
        #1;
        check("s2_second_id", 32'(irq_id), 32'h3);
        check("s2_second_irq", 32'(irq), 32'h1);
        ack("s2_ack2", 4'b1010);
        wr("s2_eoi2", 4'b1010, A_EOI, 32'h0);

        // After serving 1, a fresh rise on 1 with 3 still pending.
        do_reset("s2b_reset");
        wr("s2b_mask", 4'b0000, A_MASK, 32'hF);
        rd("s2b_rise", 4'b1010, A_STATUS);
        rd("s2b_pend", 4'b1010, A_STATUS);
        rd("s2b_irq", 4'b1010, A_STATUS);
        ack("s2b_ack", 4'b1010);
        rd("s2b_drop1", 4'b1000, A_PEND);
        rd("s2b_rerise", 4'b1010, A_PEND);
        rd("s2b_pendrd", 4'b1010, A_PEND);
        #1;
        check("s2b_pend_both", read_data, 32'hA);
        wr("s2b_eoi", 4'b1010, A_EOI, 32'h0);
        rd("s2b_idle", 4'b1010, A_STATUS);
        rd("s2b_irq2", 4'b1010, A_STATUS);
`ifdef INTC_ROUND_ROBIN_EN
        exp_second = 2'd3;
`else
        exp_second = 2'd1;
`endif
        #1;
        check("s2b_arb_id", 32'(irq_id), 32'(exp_second));

        // Masked source stays pending until enabled.
        do_reset("s3_reset");
        wr("s3_mask", 4'b0000, A_MASK, 32'hB);
        rd("s3_rise", 4'b0100, A_PEND);
        rd("s3_wait", 4'b0100, A_PEND);
        rd("s3_pend", 4'b0100, A_PEND);
        #1;
        check("s3_pend_val", read_data, 32'h4);
        check("s3_masked_irq", 32'(irq), 32'h0);
        wr("s3_unmask", 4'b0100, A_MASK, 32'hF);
        rd("s3_wait2", 4'b0100, A_STATUS);
        rd("s3_irq", 4'b0100, A_STATUS);
        #1;
        check("s3_irq_up", 32'(irq), 32'h1);
        check("s3_irq_id", 32'(irq_id), 32'h2);

        // Overrun: source 0 rises twice before acknowledge.
        do_reset("s4_reset");
        wr("s4_mask", 4'b0000, A_MASK, 32'hF);
        rd("s4_rise1", 4'b0001, A_STATUS);
        rd("s4_pend", 4'b0001, A_STATUS);
        rd("s4_irq", 4'b0001, A_STATUS);
        rd("s4_low", 4'b0000, A_STATUS);
        rd("s4_rise2", 4'b0001, A_STATUS);
        rd("s4_ovr", 4'b0001, A_STATUS);
        #1;
        check("s4_error", 32'(error), 32'h1);
        check("s4_status", read_data, 32'hC);
        wr("s4_clr", 4'b0001, A_STATUS, 32'h0);
        rd("s4_after", 4'b0001, A_STATUS);
        #1;
        check("s4_error_clr", 32'(error), 32'h0);
        check("s4_status_clr", read_data, 32'h4);

        // Timeout: keep waiting without acknowledge.
        repeat (AT + 6) rd("s5_wait", 4'b0001, A_STATUS);
        #1;
        check("s5_irq_held", 32'(irq), 32'h1);
        check("s5_id_held", 32'(irq_id), 32'h0);
        check("s5_error", 32'(error), 32'h1);
        check("s5_status", read_data, 32'h14);
        ack("s5_ack", 4'b0001);
        rd("s5_srv", 4'b0001, A_STATUS);
        #1;
        check("s5_ack_taken", 32'(irq), 32'h0);
        wr("s5_clr", 4'b0001, A_STATUS, 32'h0);
        wr("s5_eoi", 4'b0001, A_EOI, 32'h0);
        rd("s5_idle", 4'b0001, A_STATUS);
        #1;
        check("s5_status_idle", read_data, 32'h0);

        // IACK during SERVICE is ignored; reset mid-SERVICE.
        rd("s6_low", 4'b0000, A_STATUS);
        rd("s6_rise", 4'b0100, A_STATUS);
        rd("s6_pend", 4'b0100, A_STATUS);
        rd("s6_irq", 4'b0100, A_STATUS);
        ack("s6_ack", 4'b0100);
        rd("s6_srv", 4'b0100, A_STATUS);
        step("s6_stray", 1'b1, 4'b0110, 1'b1, 1'b0, A_PEND, 32'd0);
        rd("s6_pend1", 4'b0110, A_PEND);
        #1;
        check("s6_pend1_val", read_data, 32'h2);
        check("s6_stray_irq", 32'(irq), 32'h0);
        step("s6_rst", 1'b0, 4'b0110, 1'b0, 1'b0, A_MASK, 32'd0);
        #1;
        check("s6_rst_mask", read_data, 32'h0);
        check("s6_rst_irq", 32'(irq), 32'h0);
        check("s6_rst_id", 32'(irq_id), 32'h0);
        check("s6_rst_err", 32'(error), 32'h0);
        rd("s6_release", 4'b0110, A_PEND);
        #1;
        check("s6_rst_pend", read_data, 32'h0);

        // Random traffic against the model.
        wr("rnd_mask", cur_done, A_MASK, 32'hF);
        for (int c = 0; c < 2500; c++) begin
            logic        r_v, a_v, w_v;
            logic [3:0]  d_v;
            logic [31:0] ad_v, dt_v;
            r_v = ($urandom_range(0, 599) != 0);
            d_v = cur_done;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) d_v[b] = ~d_v[b];
            end
            a_v = (m_mode == M_WAIT_ACK) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 29) == 0);
            w_v = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0, 1, 2, 3: ad_v = BASE | 32'(16 + 4 * $urandom_range(0, 3));
                4:          ad_v = BASE | 32'(4 * $urandom_range(0, 3));
                default:    ad_v = $urandom;
            endcase
            dt_v = $urandom;
            step("rand", r_v, d_v, a_v, w_v, ad_v, dt_v);
        end

        rd("drain", cur_done, A_STATUS);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
